// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared encodings for the BIST host controller
package bist_pkg;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'd0,
    CMD_LOAD  = 2'd1,
    CMD_RUN   = 2'd2,
    CMD_ABORT = 2'd3
  } cmd_e;

  // Upper nibble of bist_word selects the BIST operating mode.
  localparam logic [3:0]  MODE_LOAD      = 4'h1;
  localparam logic [3:0]  MODE_RUN       = 4'h2;
  localparam logic [15:0] STATUS_PENDING = 16'hF000;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_IDLE,
    ST_LOAD_SET,
    ST_LOAD_CLK,
    ST_RUN,
    ST_REPORT
  } state_e;

endpackage

// File: rtl/bist_host_ctrl_if.sv
// rtl/bist_host_ctrl_if.sv - host command and result handshake bundle
interface bist_host_ctrl_if;
  logic [1:0]  host_cmd;
  logic [15:0] host_data;
  logic        host_valid;
  logic        host_ready;
  logic [15:0] res_data;
  logic        res_timeout;
  logic        res_valid;
  logic        res_ready;

  modport master (
    output host_cmd, host_data, host_valid, res_ready,
    input  host_ready, res_data, res_timeout, res_valid
  );

  modport slave (
    input  host_cmd, host_data, host_valid, res_ready,
    output host_ready, res_data, res_timeout, res_valid
  );
endinterface

// File: rtl/bist_host_timer.sv
// rtl/bist_host_timer.sv - loadable down-counter that holds at zero
module bist_host_timer #(
  parameter int             W       = 12,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         res_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!res_n)
      cnt <= RST_VAL;
    else if (load)
      cnt <= load_val;
    else if (dec && cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/bist_host_ctrl.sv
// rtl/bist_host_ctrl.sv - sequences BIST program load, run and reset for the host
module bist_host_ctrl
  import bist_pkg::*;
#(
  parameter int RES_CYCLES = 4,
  parameter int MAX_WORDS  = 256,
  parameter int TIMEOUT    = 4096
) (
  input  logic                    clk_50MHz,
  input  logic                    res_n,
  bist_host_ctrl_if.slave         host,
  output logic                    busy,
  output logic                    load_ovf,
  output logic [15:0]             bist_word,
  output logic                    BIST_clk_en,
  output logic                    BIST_res,
  input  logic [15:0]             bist_status
);
  localparam int TW = $clog2((TIMEOUT > RES_CYCLES ? TIMEOUT : RES_CYCLES) + 1);
  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam logic [TW-1:0] RES_LOAD  = TW'(RES_CYCLES - 1);
  localparam logic [TW-1:0] RUN_LOAD  = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] WORDS_MAX = CW'(MAX_WORDS);

  state_e        state;
  logic [CW-1:0] word_cnt;
  logic          accept, abort, done, go_reset, timer_zero;
  logic          tmr_load, tmr_dec;
  logic [TW-1:0] tmr_val;

  assign accept   = host.host_valid && host.host_ready;
  assign abort    = accept && host.host_cmd == CMD_ABORT;
  assign done     = bist_status != STATUS_PENDING;
  assign go_reset = abort || (state == ST_REPORT && host.res_ready);

  // Timer counts RESET hold cycles and RUN cycles; the last counted cycle is at zero.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = RES_LOAD;
    tmr_dec  = 1'b0;
    if (go_reset)
      tmr_load = 1'b1;
    else if (state == ST_IDLE && accept && host.host_cmd == CMD_RUN) begin
      tmr_load = 1'b1;
      tmr_val  = RUN_LOAD;
    end else
      tmr_dec = (state == ST_RESET) || (state == ST_RUN);
  end

  bist_host_timer #(.W(TW), .RST_VAL(RES_LOAD)) u_timer (
    .clk      (clk_50MHz),
    .res_n    (res_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk_50MHz) begin
    if (!res_n) begin
      state            <= ST_RESET;
      word_cnt         <= '0;
      BIST_res         <= 1'b1;
      BIST_clk_en      <= 1'b0;
      bist_word        <= '0;
      host.host_ready  <= 1'b0;
      host.res_valid   <= 1'b0;
      host.res_data    <= '0;
      host.res_timeout <= 1'b0;
      busy             <= 1'b1;
      load_ovf         <= 1'b0;
    end else if (go_reset) begin
      state           <= ST_RESET;
      word_cnt        <= '0;
      BIST_res        <= 1'b1;
      BIST_clk_en     <= 1'b1;
      bist_word       <= '0;
      host.host_ready <= 1'b0;
      host.res_valid  <= 1'b0;
      busy            <= 1'b1;
      if (abort)
        load_ovf <= 1'b0;
    end else begin
      case (state)
        ST_RESET: begin
          word_cnt <= '0;
          if (timer_zero) begin
            state           <= ST_IDLE;
            BIST_res        <= 1'b0;
            BIST_clk_en     <= 1'b0;
            host.host_ready <= 1'b1;
            busy            <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (accept && host.host_cmd == CMD_LOAD) begin
            if (word_cnt < WORDS_MAX) begin
              bist_word <= host.host_data;
              state     <= ST_LOAD_SET;
              busy      <= 1'b1;
            end else
              load_ovf <= 1'b1;
          end else if (accept && host.host_cmd == CMD_RUN) begin
            bist_word   <= {MODE_RUN, 12'h000};
            state       <= ST_RUN;
            BIST_clk_en <= 1'b1;
            busy        <= 1'b1;
          end
        end
        ST_LOAD_SET: begin
          state       <= ST_LOAD_CLK;
          BIST_clk_en <= 1'b1;
        end
        ST_LOAD_CLK: begin
          state       <= ST_IDLE;
          BIST_clk_en <= 1'b0;
          word_cnt    <= word_cnt + 1'b1;
          busy        <= 1'b0;
        end
        ST_RUN: begin
          if (done || timer_zero) begin
            host.res_data    <= bist_status;
            host.res_timeout <= !done;
            host.res_valid   <= 1'b1;
            BIST_clk_en      <= 1'b0;
            state            <= ST_REPORT;
          end
        end
        ST_REPORT: ;
        default: state <= ST_RESET;
      endcase
    end
  end
endmodule

// File: tb/tb_bist_host_ctrl.sv
// tb/tb_bist_host_ctrl.sv - self-checking bench for bist_host_ctrl
module tb_bist_host_ctrl;
  import bist_pkg::*;

  localparam int RES_CYCLES = 4;
  localparam int MAX_WORDS  = 256;
  localparam int TIMEOUT    = 16;

  logic        clk = 1'b0;
  logic        res_n = 1'b0;
  logic        busy, load_ovf, BIST_clk_en, BIST_res;
  logic [15:0] bist_word;
  logic [15:0] bist_status = STATUS_PENDING;
  int          checks = 0;
  int          errors = 0;
  int          en_total = 0;

  bist_host_ctrl_if hif();

  bist_host_ctrl #(.RES_CYCLES(RES_CYCLES), .MAX_WORDS(MAX_WORDS), .TIMEOUT(TIMEOUT)) dut (
    .clk_50MHz   (clk),
    .res_n       (res_n),
    .host        (hif),
    .busy        (busy),
    .load_ovf    (load_ovf),
    .bist_word   (bist_word),
    .BIST_clk_en (BIST_clk_en),
    .BIST_res    (BIST_res),
    .bist_status (bist_status)
  );

  always #5 clk = ~clk;

  always @(negedge clk) en_total = en_total + int'(BIST_clk_en);

  task automatic send(input logic [1:0] cmd, input logic [15:0] data);
    hif.host_cmd   = cmd;
    hif.host_data  = data;
    hif.host_valid = 1'b1;
    @(posedge clk); #1;
    hif.host_valid = 1'b0;
    hif.host_cmd   = CMD_NOP;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (!(hif.host_ready && !busy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL %s idle_wait: ready=%b busy=%b, required ready=1 busy=0", tag, hif.host_ready, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [6:0] v;
    @(posedge clk); #1;
    @(negedge clk);
    v = {BIST_res, BIST_clk_en, hif.host_ready, hif.res_valid, hif.res_timeout, busy, load_ovf};
    checks++;
    if (v !== 7'b1000010 || bist_word !== 16'h0 || hif.res_data !== 16'h0) begin
      errors++;
      $display("FAIL reset_values: flags=%b word=%h data=%h, required 1000010 0000 0000", v, bist_word, hif.res_data);
    end
    repeat (2) @(posedge clk);
    #1 res_n = 1'b1;
    for (int i = 0; i < RES_CYCLES; i++) begin
      @(negedge clk);
      checks++;
      if ({BIST_res, hif.host_ready, busy} !== 3'b101) begin
        errors++;
        $display("FAIL reset_hold[%0d]: res/ready/busy=%b, required 101", i, {BIST_res, hif.host_ready, busy});
      end
    end
    @(negedge clk);
    checks++;
    if ({BIST_res, hif.host_ready, busy, BIST_clk_en} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_exit: res/ready/busy/en=%b, required 0100", {BIST_res, hif.host_ready, busy, BIST_clk_en});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load();
    logic [15:0] w;
    int base;
    for (int i = 0; i < 4; i++) begin
      w = (i == 0) ? 16'h1A35 : 16'($urandom);
      base = en_total;
      send(CMD_LOAD, w);
      @(negedge clk);
      checks++;
      if ({bist_word, BIST_clk_en} !== {w, 1'b0}) begin
        errors++;
        $display("FAIL load_setup[%0d]: word=%h en=%b, required %h 0", i, bist_word, BIST_clk_en, w);
      end
      @(negedge clk);
      checks++;
      if ({bist_word, BIST_clk_en} !== {w, 1'b1}) begin
        errors++;
        $display("FAIL load_pulse[%0d]: word=%h en=%b, required %h 1", i, bist_word, BIST_clk_en, w);
      end
      @(negedge clk);
      checks++;
      if ({BIST_clk_en, hif.host_ready, busy} !== 3'b010) begin
        errors++;
        $display("FAIL load_return[%0d]: en/ready/busy=%b, required 010", i, {BIST_clk_en, hif.host_ready, busy});
      end
      @(posedge clk); #1;
      checks++;
      if (en_total - base !== 1) begin
        errors++;
        $display("FAIL load_pulse_count[%0d]: %0d pulses, required 1", i, en_total - base);
      end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] w, last;
    logic ovf_before;
    int base, n_loads, exp_pulses;
    send(CMD_ABORT, 16'h0);
    wait_idle("overflow_prep");
    n_loads = MAX_WORDS + 1;
    exp_pulses = (n_loads > MAX_WORDS) ? MAX_WORDS : n_loads;
    last = 16'h0;
    ovf_before = 1'bx;
    base = en_total;
    for (int i = 0; i < n_loads; i++) begin
      w = 16'($urandom);
      if (i < MAX_WORDS) last = w;
      send(CMD_LOAD, w);
      @(posedge clk); #1;
      @(posedge clk); #1;
      if (i == MAX_WORDS - 1) ovf_before = load_ovf;
    end
    checks++;
    if (ovf_before !== 1'b0) begin
      errors++;
      $display("FAIL ovf_early: load_ovf=%b after %0d words, required 0", ovf_before, MAX_WORDS);
    end
    checks++;
    if (en_total - base !== exp_pulses) begin
      errors++;
      $display("FAIL ovf_pulses: %0d pulses, required %0d", en_total - base, exp_pulses);
    end
    checks++;
    if ({load_ovf, busy, bist_word} !== {1'b1, 1'b0, last}) begin
      errors++;
      $display("FAIL ovf_state: ovf=%b busy=%b word=%h, required 1 0 %h", load_ovf, busy, bist_word, last);
    end
  endtask

  task automatic test_abort(input int d, input logic [15:0] v);
    logic seen_valid;
    checks++;
    if (load_ovf !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre_ovf: load_ovf=%b, required 1", load_ovf);
    end
    bist_status = STATUS_PENDING;
    send(CMD_RUN, 16'h0);
    repeat (d) begin @(posedge clk); #1; end
    bist_status = v;
    send(CMD_ABORT, 16'h0);
    @(negedge clk);
    checks++;
    if ({hif.res_valid, BIST_res, hif.host_ready, load_ovf, BIST_clk_en, bist_word} !== {5'b01001, 16'h0}) begin
      errors++;
      $display("FAIL abort_entry: valid/res/ready/ovf/en=%b word=%h, required 01001 0000",
               {hif.res_valid, BIST_res, hif.host_ready, load_ovf, BIST_clk_en}, bist_word);
    end
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (hif.res_valid) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_dropped: res_valid seen=%b, required 0", seen_valid);
    end
    bist_status = STATUS_PENDING;
    wait_idle("abort");
  endtask

  task automatic run_once(input int d, input logic [15:0] v, input int hold);
    int base, exp_en;
    logic exp_to, seen, dropped;
    logic [15:0] exp_data;
    exp_to   = (d + 1 > TIMEOUT);
    exp_data = exp_to ? STATUS_PENDING : v;
    exp_en   = exp_to ? TIMEOUT : d + 1;
    bist_status = STATUS_PENDING;
    base = en_total;
    send(CMD_RUN, 16'($urandom));
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (c == d) bist_status = v;
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if ({BIST_clk_en, bist_word} !== {1'b1, MODE_RUN, 12'h000}) begin
          errors++;
          $display("FAIL run_start: en=%b word=%h, required 1 %h", BIST_clk_en, bist_word, {MODE_RUN, 12'h000});
        end
      end
      if (hif.res_valid) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    checks++;
    if (!seen || {BIST_clk_en, hif.res_timeout, hif.res_data} !== {1'b0, exp_to, exp_data}) begin
      errors++;
      $display("FAIL run_result d=%0d: seen=%b en=%b to=%b data=%h, required 1 0 %b %h",
               d, seen, BIST_clk_en, hif.res_timeout, hif.res_data, exp_to, exp_data);
    end
    @(posedge clk); #1;
    checks++;
    if (en_total - base !== exp_en) begin
      errors++;
      $display("FAIL run_en_cycles d=%0d: %0d, required %0d", d, en_total - base, exp_en);
    end
    dropped = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!hif.res_valid) dropped = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (dropped !== 1'b0) begin
      errors++;
      $display("FAIL run_backpressure: res_valid dropped=%b while res_ready low, required 0", dropped);
    end
    hif.res_ready = 1'b1;
    @(posedge clk); #1;
    hif.res_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({hif.res_valid, BIST_res, hif.host_ready} !== 3'b010) begin
      errors++;
      $display("FAIL run_release: valid/res/ready=%b, required 010", {hif.res_valid, BIST_res, hif.host_ready});
    end
    wait_idle("run");
  endtask

  task automatic test_midrun_reset();
    bist_status = STATUS_PENDING;
    send(CMD_RUN, 16'h0);
    repeat (3) begin @(posedge clk); #1; end
    res_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({BIST_clk_en, BIST_res, hif.host_ready, busy} !== 4'b0101) begin
      errors++;
      $display("FAIL midrun_reset: en/res/ready/busy=%b, required 0101", {BIST_clk_en, BIST_res, hif.host_ready, busy});
    end
    @(posedge clk); #1;
    res_n = 1'b1;
    wait_idle("midrun_reset");
  endtask

  initial begin
    logic [15:0] v;
    hif.host_cmd   = CMD_NOP;
    hif.host_data  = 16'h0;
    hif.host_valid = 1'b0;
    hif.res_ready  = 1'b0;
    test_reset();
    test_load();
    test_overflow();
    test_abort(int'($urandom_range(2, 10)), 16'h00A5);
    run_once(10, 16'h00A5, 2);
    run_once(100, 16'h1234, 6);
    run_once(TIMEOUT - 1, 16'h0042, 1);
    run_once(TIMEOUT, 16'h0042, 1);
    for (int i = 0; i < 6; i++) begin
      v = 16'($urandom);
      if (v == STATUS_PENDING) v = 16'h0;
      run_once(int'($urandom_range(0, 20)), v, int'($urandom_range(0, 5)));
    end
    test_midrun_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
